// File: rtl/nested_loop_sequencer_if.sv
// Start/done handshake and index bus between the control FSM and the nested loop sequencer.
// The abort/aborted pair exists only when SEQ_ABORT_EN is defined.
interface nested_loop_sequencer_if #(
    parameter int WORD_LENGTH = 8
);
    logic                   start;
    logic [WORD_LENGTH:0]   inner_max;
    logic [WORD_LENGTH:0]   outer_max;
    logic                   stall;
    logic                   busy;
    logic                   step_valid;
    logic [WORD_LENGTH-1:0] inner_idx;
    logic [WORD_LENGTH-1:0] outer_idx;
    logic                   inner_last;
    logic                   outer_last;
    logic                   done;
`ifdef SEQ_ABORT_EN
    logic                   abort;
    logic                   aborted;

    modport master (
        output start, inner_max, outer_max, stall, abort,
        input  busy, step_valid, inner_idx, outer_idx, inner_last, outer_last, done, aborted
    );
    modport slave (
        input  start, inner_max, outer_max, stall, abort,
        output busy, step_valid, inner_idx, outer_idx, inner_last, outer_last, done, aborted
    );
`else
    modport master (
        output start, inner_max, outer_max, stall,
        input  busy, step_valid, inner_idx, outer_idx, inner_last, outer_last, done
    );
    modport slave (
        input  start, inner_max, outer_max, stall,
        output busy, step_valid, inner_idx, outer_idx, inner_last, outer_last, done
    );
`endif
endinterface

// File: rtl/nested_loop_sequencer.sv
// Two-level loop sequencer: walks (outer, inner) pairs in row-major order, one step per unstalled cycle.
// Optional early termination via abort/aborted when SEQ_ABORT_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; bounds and indices hold
// RUN   | issuing steps; stall holds everything
// DONE  | one-cycle done pulse, then back to IDLE
module nested_loop_sequencer #(
    parameter int WORD_LENGTH = 8
) (
    input logic clk,
    input logic rst,
    nested_loop_sequencer_if.slave sif
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [WORD_LENGTH:0] ONE = {{WORD_LENGTH{1'b0}}, 1'b1};

    state_t                 state_q, state_d;
    logic [WORD_LENGTH:0]   inner_bnd, outer_bnd;
    logic [WORD_LENGTH-1:0] inner_q, outer_q;
    logic                   aborted_q;
    logic                   abort_now;
    logic                   zero_bound;
    logic                   inner_at_last, outer_at_last;
    logic                   step, last_step;

`ifdef SEQ_ABORT_EN
    assign abort_now = (state_q == RUN) && sif.abort;
`else
    assign abort_now = 1'b0;
`endif

    assign zero_bound    = (sif.inner_max == '0) || (sif.outer_max == '0);
    // Compare at WORD_LENGTH+1 bits so a bound of 2^WORD_LENGTH lands on the all-ones code.
    assign inner_at_last = ({1'b0, inner_q} == (inner_bnd - ONE));
    assign outer_at_last = ({1'b0, outer_q} == (outer_bnd - ONE));
    assign step          = (state_q == RUN) && !sif.stall && !abort_now;
    assign last_step     = step && inner_at_last && outer_at_last;

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (sif.start) state_d = zero_bound ? DONE : RUN;
            RUN:     if (abort_now || last_step) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            inner_bnd <= '0;
            outer_bnd <= '0;
            inner_q   <= '0;
            outer_q   <= '0;
            aborted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sif.start) begin
                        inner_q   <= '0;
                        outer_q   <= '0;
                        aborted_q <= 1'b0;
                        if (!zero_bound) begin
                            inner_bnd <= sif.inner_max;
                            outer_bnd <= sif.outer_max;
                        end
                    end
                end
                RUN: begin
                    if (abort_now) begin
                        aborted_q <= 1'b1;
                    end else if (step && !last_step) begin
                        if (inner_at_last) begin
                            inner_q <= '0;
                            outer_q <= outer_q + 1'b1;
                        end else begin
                            inner_q <= inner_q + 1'b1;
                        end
                    end
                end
                DONE:    aborted_q <= 1'b0;
                default: aborted_q <= 1'b0;
            endcase
        end
    end

    always_comb begin
        sif.busy       = (state_q == RUN) || (state_q == DONE);
        sif.done       = (state_q == DONE);
        sif.step_valid = step;
        sif.inner_idx  = inner_q;
        sif.outer_idx  = outer_q;
        sif.inner_last = (state_q == RUN) && inner_at_last;
        sif.outer_last = (state_q == RUN) && outer_at_last;
`ifdef SEQ_ABORT_EN
        sif.aborted    = (state_q == DONE) && aborted_q;
`endif
    end
endmodule
